// File: rtl/draw_command_sequencer.sv
// Frame-synchronous draw command sequencer: buffers commands in a FIFO, then on each
// submit waits for a frame edge, issues one clear and replays the batch over a 4-phase handshake.
module draw_command_sequencer #(
    parameter int DEPTH = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         wr_valid,
    input  logic [31:0]                  wr_img_id,
    input  logic [9:0]                   wr_x,
    input  logic [9:0]                   wr_y,
    output logic                         wr_ready,
    input  logic                         frame_submit,
    output logic                         submit_ready,
    output logic                         frame_done,
    output logic                         submit_drop,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [31:0]                  img_id,
    output logic [9:0]                   imgX,
    output logic [9:0]                   imgY,
    output logic                         draw_start,
    output logic                         clear_start,
    input  logic                         done,
    input  logic                         frame_clk
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, WAIT_FE, CLEAR, CLR_REL, FETCH, DRAW, DRW_REL, FIN
    } state_t;

    state_t          state, state_next;
    logic [51:0]     mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   count_next;
    logic [CW-1:0]   batch;
    logic            frame_clk_q;
    logic            fe, push, pop, accept;
    logic            draw_next, clear_next;

    assign fe   = frame_clk & ~frame_clk_q;
    assign push = wr_valid & wr_ready;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_submit) state_next = WAIT_FE;
            WAIT_FE: if (fe)           state_next = CLEAR;
            CLEAR:   if (done)         state_next = CLR_REL;
            CLR_REL: if (!done)        state_next = (batch != '0) ? FETCH : FIN;
            FETCH:                     state_next = DRAW;
            DRAW:    if (done)         state_next = DRW_REL;
            DRW_REL: if (!done)        state_next = (batch != '0) ? FETCH : FIN;
            FIN:                       state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Start requests are registered from the next state so they never overlap.
    always_comb begin
        submit_ready = (state == IDLE);
        frame_done   = (state == FIN);
        pop          = (state == FETCH);
        accept       = frame_submit & (state == IDLE);
        draw_next    = (state_next == DRAW);
        clear_next   = (state_next == CLEAR);
    end

    always_comb begin
        count_next = fifo_count;
        case ({push, pop})
            2'b10:   count_next = fifo_count + CW'(1);
            2'b01:   count_next = fifo_count - CW'(1);
            default: count_next = fifo_count;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) mem[wptr] <= {wr_img_id, wr_x, wr_y};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
            wptr        <= '0;
            rptr        <= '0;
            fifo_count  <= '0;
            wr_ready    <= 1'b1;
            batch       <= '0;
            submit_drop <= 1'b0;
            draw_start  <= 1'b0;
            clear_start <= 1'b0;
            img_id      <= '0;
            imgX        <= '0;
            imgY        <= '0;
        end else begin
            frame_clk_q <= frame_clk;
            fifo_count  <= count_next;
            // Registered from the next count so a full FIFO blocks the very next push.
            wr_ready    <= (count_next != CW'(DEPTH));
            draw_start  <= draw_next;
            clear_start <= clear_next;
            if (push) wptr <= wptr + AW'(1);
            if (frame_submit && !accept) submit_drop <= 1'b1;
            if (accept) begin
                batch <= fifo_count;
            end else if (pop) begin
                batch <= batch - CW'(1);
            end
            if (pop) begin
                rptr                 <= rptr + AW'(1);
                {img_id, imgX, imgY} <= mem[rptr];
            end
        end
    end
endmodule

// File: tb/tb_draw_command_sequencer.sv
// Directed bench for draw_command_sequencer with a behavioural accelerator that
// answers each start request with done four cycles later.
module tb_draw_command_sequencer;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_img_id = '0;
    logic [9:0]  wr_x = '0;
    logic [9:0]  wr_y = '0;
    logic        wr_ready;
    logic        frame_submit = 1'b0;
    logic        submit_ready;
    logic        frame_done;
    logic        submit_drop;
    logic [4:0]  fifo_count;
    logic [31:0] img_id;
    logic [9:0]  imgX;
    logic [9:0]  imgY;
    logic        draw_start;
    logic        clear_start;
    logic        done = 1'b0;
    logic        frame_clk = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [51:0] draw_log [64];
    int draw_n = 0;
    int clr_n = 0;
    int both_n = 0;

    draw_command_sequencer #(.DEPTH(16)) dut (
        .Clk(Clk), .Reset(Reset), .wr_valid(wr_valid), .wr_img_id(wr_img_id),
        .wr_x(wr_x), .wr_y(wr_y), .wr_ready(wr_ready), .frame_submit(frame_submit),
        .submit_ready(submit_ready), .frame_done(frame_done), .submit_drop(submit_drop),
        .fifo_count(fifo_count), .img_id(img_id), .imgX(imgX), .imgY(imgY),
        .draw_start(draw_start), .clear_start(clear_start), .done(done),
        .frame_clk(frame_clk)
    );

    always #5 Clk = ~Clk;

    // Accelerator model and request monitor, sampled just after each rising edge.
    initial begin
        int  busy_cyc;
        logic prev_draw, prev_clr;
        busy_cyc = 0;
        prev_draw = 1'b0;
        prev_clr = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (draw_start && !prev_draw && draw_n < 64) begin
                draw_log[draw_n] = {img_id, imgX, imgY};
                draw_n = draw_n + 1;
            end
            if (clear_start && !prev_clr) clr_n = clr_n + 1;
            if (draw_start && clear_start) both_n = both_n + 1;
            prev_draw = draw_start;
            prev_clr = clear_start;
            if (draw_start || clear_start) begin
                busy_cyc = busy_cyc + 1;
                if (busy_cyc >= 4) done = 1'b1;
            end else begin
                busy_cyc = 0;
                done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] id, input logic [9:0] x, input logic [9:0] y);
        wr_valid = 1'b1;
        wr_img_id = id;
        wr_x = x;
        wr_y = y;
        @(negedge Clk);
        wr_valid = 1'b0;
    endtask

    task automatic submit();
        frame_submit = 1'b1;
        @(negedge Clk);
        frame_submit = 1'b0;
    endtask

    task automatic frame_pulse(input string tag);
        frame_clk = 1'b1;
        @(negedge Clk);
        check(tag, clear_start, 1'b1);
        frame_clk = 1'b0;
    endtask

    task automatic wait_frame_done(input string tag);
        int k;
        k = 0;
        while (!frame_done && k < 2000) begin
            @(negedge Clk);
            k = k + 1;
        end
        if (!frame_done) check({tag, "_timeout"}, 1'b0, 1'b1);
        @(negedge Clk);
        check({tag, "_pulse"}, frame_done, 1'b0);
    endtask

    task automatic wait_draw(input string tag);
        int k;
        k = 0;
        while (!draw_start && k < 2000) begin
            @(negedge Clk);
            k = k + 1;
        end
        if (!draw_start) check({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        int c0, d0;
        repeat (2) @(negedge Clk);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_submit_ready", submit_ready, 1'b1);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_drop", submit_drop, 1'b0);
        check("rst_count", fifo_count, 5'd0);
        check("rst_img", {img_id, imgX, imgY}, 52'd0);
        check("rst_starts", {draw_start, clear_start}, 2'b00);
        Reset = 1'b0;
        @(negedge Clk);

        // Basic three-command frame
        c0 = clr_n; d0 = draw_n;
        push(32'd1, 10'd10, 10'd5);
        push(32'd2, 10'd20, 10'd5);
        push(32'd3, 10'd30, 10'd5);
        check("t1_count", fifo_count, 5'd3);
        submit();
        check("t1_busy", submit_ready, 1'b0);
        repeat (3) @(negedge Clk);
        check("t1_no_clr_early", clear_start, 1'b0);
        frame_pulse("t1_clr_lat");
        wait_frame_done("t1_fd");
        check("t1_clears", clr_n - c0, 1);
        check("t1_draws", draw_n - d0, 3);
        check("t1_d0", draw_log[d0], {32'd1, 10'd10, 10'd5});
        check("t1_d1", draw_log[d0+1], {32'd2, 10'd20, 10'd5});
        check("t1_d2", draw_log[d0+2], {32'd3, 10'd30, 10'd5});
        check("t1_count_end", fifo_count, 5'd0);
        check("t1_idle", submit_ready, 1'b1);
        check("t1_hold_img", {img_id, imgX, imgY}, {32'd3, 10'd30, 10'd5});

        // Fill to DEPTH, overflow push ignored, then drain
        for (int i = 0; i < 16; i++) push(32'd100 + i, 10'(i), 10'(2 * i));
        check("t2_full_ready", wr_ready, 1'b0);
        check("t2_full_count", fifo_count, 5'd16);
        push(32'd999, 10'd1, 10'd1);
        check("t2_over_count", fifo_count, 5'd16);
        c0 = clr_n; d0 = draw_n;
        submit();
        frame_pulse("t2_clr_lat");
        wait_frame_done("t2_fd");
        check("t2_draws", draw_n - d0, 16);
        check("t2_first", draw_log[d0], {32'd100, 10'd0, 10'd0});
        check("t2_last", draw_log[d0+15], {32'd115, 10'd15, 10'd30});
        check("t2_count_end", fifo_count, 5'd0);
        check("t2_ready_end", wr_ready, 1'b1);

        // Empty submit: clear only
        c0 = clr_n; d0 = draw_n;
        submit();
        frame_pulse("t3_clr_lat");
        wait_frame_done("t3_fd");
        check("t3_clears", clr_n - c0, 1);
        check("t3_draws", draw_n - d0, 0);

        // Submit during execution is dropped; later pushes wait for the next frame
        c0 = clr_n; d0 = draw_n;
        push(32'd41, 10'd1, 10'd2);
        push(32'd42, 10'd3, 10'd4);
        submit();
        frame_pulse("t4_clr_lat");
        wait_draw("t4_draw");
        push(32'd43, 10'd5, 10'd6);
        push(32'd44, 10'd7, 10'd8);
        submit();
        check("t4_drop", submit_drop, 1'b1);
        wait_frame_done("t4_fd");
        check("t4_draws", draw_n - d0, 2);
        check("t4_d1", draw_log[d0+1], {32'd42, 10'd3, 10'd4});
        check("t4_count_end", fifo_count, 5'd2);
        check("t4_idle", submit_ready, 1'b1);

        // frame_clk already high at submit is not an edge
        c0 = clr_n; d0 = draw_n;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        submit();
        repeat (8) @(negedge Clk);
        check("t5_no_clear", clr_n - c0, 0);
        check("t5_waiting", submit_ready, 1'b0);
        frame_clk = 1'b0;
        @(negedge Clk);
        frame_pulse("t5_clr_lat");
        wait_frame_done("t5_fd");
        check("t5_draws", draw_n - d0, 2);
        check("t5_d0", draw_log[d0], {32'd43, 10'd5, 10'd6});
        check("t5_d1", draw_log[d0+1], {32'd44, 10'd7, 10'd8});

        // Asynchronous reset mid-draw
        push(32'd7, 10'd7, 10'd7);
        push(32'd8, 10'd8, 10'd8);
        push(32'd9, 10'd9, 10'd9);
        submit();
        frame_pulse("t6_clr_lat");
        wait_draw("t6_draw");
        check("t6_pre_draw", draw_start, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("t6_draw_off", draw_start, 1'b0);
        check("t6_count", fifo_count, 5'd0);
        check("t6_submit_ready", submit_ready, 1'b1);
        check("t6_drop_clr", submit_drop, 1'b0);
        check("t6_img", {img_id, imgX, imgY}, 52'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        check("no_overlap", both_n, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/draw_command_sequencer.md
# draw_command_sequencer

Command-side initiator for the graphics accelerator's software interface. Buffers draw commands (image id plus screen position) from the software register bank in a FIFO. On each frame submit, it waits for the next frame boundary, issues one clear, then replays the submitted draw commands over the `draw_start`/`clear_start`/`done` handshake. It sits between the Avalon-side register file and the accelerator, and replaces direct software polling of `done`.

## Interface
- `DEPTH`, 16 — FIFO entries; power of two, ≥2.
- `Clk`  in  1  system clock; all logic rising-edge.
- `Reset`  in  1  asynchronous, active-high; clears FIFO, counters and FSM.
- `wr_valid`  in  1  push request for one command.
- `wr_img_id`  in  32  image id for the pushed command.
- `wr_x`  in  10  X position for the pushed command.
- `wr_y`  in  10  Y position for the pushed command.
- `wr_ready`  out  1  FIFO not full; a push occurs only when `wr_valid & wr_ready`.
- `frame_submit`  in  1  single-cycle pulse that closes the current frame's command list.
- `submit_ready`  out  1  high when no frame is pending or executing.
- `frame_done`  out  1  single-cycle pulse after the last command of a frame completes.
- `submit_drop`  out  1  sticky flag; set when a submit is rejected; cleared only by `Reset`.
- `fifo_count`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `img_id`  out  32  command image id to the accelerator.
- `imgX`  out  10  command X position to the accelerator.
- `imgY`  out  10  command Y position to the accelerator.
- `draw_start`  out  1  level draw request.
- `clear_start`  out  1  level clear request.
- `done`  in  1  accelerator completion.
- `frame_clk`  in  1  accelerator frame-boundary signal, same clock domain.

## Operation
- FIFO: entries are 52 bits wide (`{img_id, x, y}`). The write pointer and read pointer are each `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `fifo_count` increments on a push, decrements on a pop, and is unchanged when both occur in the same cycle.
- Submit: when `frame_submit` occurs in IDLE, the sequencer latches `batch = fifo_count` as of that same cycle. A push in the same cycle is not counted in that batch. Commands pushed after the submit belong to the next frame.
- A `frame_submit` outside IDLE is ignored and sets `submit_drop`.
- A submit with `fifo_count == 0` is still valid: the frame performs the clear only, then pulses `frame_done`.
- Frame edge: `fe = frame_clk & ~frame_clk_q`, where `frame_clk_q` is a registered copy of `frame_clk`. `frame_clk_q` resets to 0.
- Handshake (4-phase): the sequencer drives a start signal high with `img_id`/`imgX`/`imgY` stable. It holds the start signal until it samples `done = 1`, then drops it. It does not raise the next start until it samples `done = 0`.
- States:
  - IDLE: `submit_ready = 1`. On `frame_submit` go to WAIT_FE.
  - WAIT_FE: on `fe` go to CLEAR.
  - CLEAR: `clear_start = 1`. On `done` go to CLR_REL.
  - CLR_REL: on `~done` go to FETCH if `batch != 0`, else go to FIN.
  - FETCH: pop the head entry into the output registers and decrement `batch`, then go to DRAW.
  - DRAW: `draw_start = 1`. On `done` go to DRW_REL.
  - DRW_REL: on `~done` go to FETCH if `batch != 0`, else go to FIN.
  - FIN: `frame_done = 1` for one cycle, then go to IDLE.
- `draw_start` and `clear_start` are registered outputs and are never high together.
- Pushes remain legal in every state. A pop (FETCH only) and a push may occur in the same cycle.
- The FIFO cannot underflow, because `batch ≤ fifo_count` always holds.

## Timing
- Reset values: `wr_ready = 1`, `submit_ready = 1`, `frame_done = 0`, `submit_drop = 0`, `fifo_count = 0`, `img_id = 0`, `imgX = 0`, `imgY = 0`, `draw_start = 0`, `clear_start = 0`, state = IDLE.
- `wr_ready` is `fifo_count != DEPTH`, registered from the count. When the FIFO is full, a push is ignored with no error.
- Latencies:
  - Submit to WAIT_FE: 1 cycle.
  - `fe` to `clear_start` high: 1 cycle.
  - `done` sampled high to start low: 1 cycle.
  - `done` low to next `draw_start` high: 2 cycles (FETCH plus 1).
- Outputs `img_id`/`imgX`/`imgY` update only in FETCH and hold until the next FETCH.
- A `frame_clk` level that is already high on entry to WAIT_FE does not count as an edge; the sequencer waits for the next rise.
- `Reset` mid-frame: all outputs return to their reset values asynchronously, queued commands are discarded, and an in-flight accelerator operation is abandoned. The accelerator shares this reset.

## Test plan
- Reset, push 3 commands (ids 1,2,3; x=10/20/30; y=5), submit, pulse `frame_clk`; model `done` at 4 cycles after start → sequence is one clear, then draws with ids 1,2,3 in order, then one `frame_done` pulse; `fifo_count` = 0 at end.
- Push `DEPTH` commands, then one more → `wr_ready` = 0 after the 16th push, the 17th push is ignored, `fifo_count` = 16.
- Submit with an empty FIFO → exactly one `clear_start` handshake, then `frame_done`, with no `draw_start`.
- Submit 2 commands; during DRAW, push 2 more and pulse `frame_submit` → `submit_drop` = 1, only 2 draws occur, and `fifo_count` = 2 after `frame_done`.
- Hold `frame_clk` high at submit → no clear until `frame_clk` falls and rises again.
- Assert `Reset` while `draw_start` = 1 → `draw_start` = 0 immediately, `fifo_count` = 0, `submit_ready` = 1.
